// File: rtl/therm_stable_decoder.sv
// Thermometer bubble corrector and k decoder with a consecutive-sample debounce
// filter; each newly stable k is published on a valid/ready output port.
module therm_stable_decoder #(
   parameter  int N          = 5,
   parameter  int STABLE_CNT = 3,
   localparam int CW         = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  in_therm,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [CW-1:0] out_count,
   output logic          out_bubble,
   output logic          out_valid,
   input  logic          out_ready
);

   localparam int NW = $clog2(STABLE_CNT + 1);
   localparam logic [NW-1:0] CNT_MAX = NW'(STABLE_CNT);

   logic          stall;
   logic [N+1:0]  ext;
   logic [N-1:0]  corr;
   logic          raw_bub;

   logic          s1_vld;
   logic [N-1:0]  s1_c;
   logic          s1_b;
   logic [CW-1:0] s1_ones;
   logic [CW-1:0] s1_k;

   logic [CW-1:0] cand, cand_nxt;
   logic [NW-1:0] cnt, cnt_nxt;
   logic          pub_vld;
   logic          sticky_bub;
   logic          publish;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   // Pad with the implied t[-1]=0 and t[N]=1 so the edge bits vote like the rest.
   assign ext     = {1'b1, in_therm, 1'b0};
   assign raw_bub = |(in_therm[N-2:0] & ~in_therm[N-1:1]);

   always_comb begin
      corr = '0;
      for (int unsigned i = 0; i < N; i++) begin
         corr[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
      end
   end

   always_comb begin
      s1_ones = '0;
      for (int unsigned i = 0; i < N; i++) begin
         s1_ones = s1_ones + CW'(s1_c[i]);
      end
      s1_k = CW'(N) - s1_ones;
   end

   always_comb begin
      cand_nxt = cand;
      cnt_nxt  = cnt;
      if (s1_k == cand) begin
         if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
      end else begin
         cand_nxt = s1_k;
         cnt_nxt  = NW'(1);
      end
      publish = s1_vld && !stall && (cnt_nxt == CNT_MAX)
                && (!pub_vld || (cand_nxt != out_count));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld     <= 1'b0;
         s1_c       <= '0;
         s1_b       <= 1'b0;
         cand       <= '0;
         cnt        <= '0;
         pub_vld    <= 1'b0;
         sticky_bub <= 1'b0;
         out_count  <= '0;
         out_bubble <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         if (!stall) begin
            s1_vld <= in_valid;
            if (in_valid) begin
               s1_c <= corr;
               s1_b <= raw_bub;
            end
         end
         if (s1_vld && !stall) begin
            cand       <= cand_nxt;
            cnt        <= cnt_nxt;
            sticky_bub <= publish ? 1'b0 : (sticky_bub | s1_b);
         end
         // A publish landing on the handshake cycle keeps out_valid asserted.
         if (publish) begin
            out_count  <= cand_nxt;
            out_bubble <= sticky_bub | s1_b;
            out_valid  <= 1'b1;
            pub_vld    <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_therm_stable_decoder.sv
// Bench for therm_stable_decoder: vector table, corner-case sequences and a
// randomized run checked every cycle against a behavioural model.
module tb_therm_stable_decoder;

   localparam int N  = 5;
   localparam int ST = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] in_therm;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] out_count;
   logic       out_bubble;
   logic       out_valid;
   logic       out_ready;

   therm_stable_decoder #(.N(N), .STABLE_CNT(ST)) dut (
      .clk(clk), .rst(rst), .in_therm(in_therm), .in_valid(in_valid),
      .in_ready(in_ready), .out_count(out_count), .out_bubble(out_bubble),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model state
   bit m_s1v, m_s1b, m_pubv, m_sticky, m_ov, m_ob;
   int m_s1k, m_cand, m_cnt, m_oc;
   bit mchk;

   // Observed DUT values from the latest tick
   int obs_ov, obs_cnt, obs_b, obs_ir;

   typedef struct {
      logic       r;
      logic [4:0] t;
      logic       v;
      logic       rdy;
      logic       eov;
      int         ecnt;
      logic       eb;
      logic       eir;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // k is the count of zeros after a per-bit 3-way majority vote.
   function automatic int kof(input logic [4:0] t);
      int e[N+2];
      int k;
      k = 0;
      e[0] = 0;
      e[N+1] = 1;
      for (int i = 0; i < N; i++) e[i+1] = int'(t[i]);
      for (int i = 0; i < N; i++)
         if (e[i] + e[i+1] + e[i+2] < 2) k++;
      return k;
   endfunction

   function automatic bit bubof(input logic [4:0] t);
      for (int i = 0; i < N - 1; i++)
         if (t[i] == 1'b1 && t[i+1] == 1'b0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step(input logic r, input logic [4:0] t, input logic v, input logic rdy);
      bit stall;
      stall = m_ov && !rdy;
      if (r) begin
         m_s1v = 0; m_s1b = 0; m_s1k = 0; m_cand = 0; m_cnt = 0;
         m_pubv = 0; m_sticky = 0; m_ov = 0; m_oc = 0; m_ob = 0;
         return;
      end
      if (stall) return;
      if (m_ov && rdy) m_ov = 0;
      if (m_s1v) begin
         if (m_s1k == m_cand) m_cnt = (m_cnt + 1 > ST) ? ST : m_cnt + 1;
         else begin m_cand = m_s1k; m_cnt = 1; end
         if (m_cnt == ST && (!m_pubv || m_cand != m_oc)) begin
            m_oc = m_cand; m_ob = m_sticky | m_s1b; m_ov = 1; m_pubv = 1; m_sticky = 0;
         end else begin
            m_sticky = m_sticky | m_s1b;
         end
      end
      m_s1v = v;
      if (v) begin m_s1k = kof(t); m_s1b = bubof(t); end
   endtask

   // Drive one cycle of inputs, sample mid-cycle, compare with the model, advance.
   task automatic tick(input logic r, input logic [4:0] t, input logic v, input logic rdy);
      rst = r; in_therm = t; in_valid = v; out_ready = rdy;
      #4;
      obs_ov = int'(out_valid); obs_cnt = int'(out_count);
      obs_b = int'(out_bubble); obs_ir = int'(in_ready);
      if (mchk) begin
         chk("model_in_ready", obs_ir, int'(!(m_ov && !rdy)));
         chk("model_out_valid", obs_ov, int'(m_ov));
         if (m_ov) begin
            chk("model_out_count", obs_cnt, m_oc);
            chk("model_out_bubble", obs_b, int'(m_ob));
         end
      end
      model_step(r, t, v, rdy);
      mchk = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic [4:0] t, input logic v, input logic rdy,
                      input logic eov, input int ecnt, input logic eb, input logic eir);
      vec_t x;
      x.r = r; x.t = t; x.v = v; x.rdy = rdy; x.eov = eov; x.ecnt = ecnt; x.eb = eb; x.eir = eir;
      tbl.push_back(x);
   endtask

   // Run idle cycles, counting records seen; returns count and the last k.
   task automatic watch(input int cycles, output int recs, output int lastk);
      recs = 0; lastk = -1;
      for (int i = 0; i < cycles; i++) begin
         tick(1'b0, 5'b00000, 1'b0, 1'b1);
         if (obs_ov == 1) begin recs++; lastk = obs_cnt; end
      end
   endtask

   initial begin
      int recs, lastk, waited, cur_k;
      logic [4:0] t;
      mchk = 0;
      rst = 1; in_therm = '0; in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      tick(1'b1, 5'b00000, 1'b0, 1'b1);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_count", int'(out_count), 0);
      chk("reset_out_bubble", int'(out_bubble), 0);

      // basic publish, bubble, stall
      for (int i = 0; i < 3; i++) add(0, 5'b11100, 1, 1, 0, 0, 0, 1);
      add(0, 5'b00000, 0, 1, 0, 0, 0, 1);
      add(0, 5'b00000, 0, 1, 1, 2, 0, 1);
      add(0, 5'b00000, 0, 1, 0, 0, 0, 1);
      add(1, 5'b00000, 0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) add(0, 5'b11010, 1, 1, 0, 0, 0, 1);
      add(0, 5'b00000, 0, 1, 0, 0, 0, 1);
      add(0, 5'b00000, 0, 1, 1, 2, 1, 1);
      for (int i = 0; i < 3; i++) add(0, 5'b11100, 1, 1, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) add(0, 5'b00000, 0, 1, 0, 0, 0, 1);
      add(1, 5'b00000, 0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) add(0, 5'b11100, 1, 1, 0, 0, 0, 1);
      add(0, 5'b10000, 1, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) add(0, 5'b10000, 1, 0, 1, 2, 0, 0);
      add(0, 5'b10000, 1, 1, 1, 2, 0, 1);
      add(0, 5'b10000, 1, 1, 0, 0, 0, 1);
      add(0, 5'b00000, 0, 1, 0, 0, 0, 1);
      add(0, 5'b00000, 0, 1, 1, 4, 0, 1);
      add(0, 5'b00000, 0, 1, 0, 0, 0, 1);

      foreach (tbl[i]) begin
         tick(tbl[i].r, tbl[i].t, tbl[i].v, tbl[i].rdy);
         chk($sformatf("tbl%0d_in_ready", i), obs_ir, int'(tbl[i].eir));
         chk($sformatf("tbl%0d_out_valid", i), obs_ov, int'(tbl[i].eov));
         if (tbl[i].eov) begin
            chk($sformatf("tbl%0d_out_count", i), obs_cnt, tbl[i].ecnt);
            chk($sformatf("tbl%0d_out_bubble", i), obs_b, int'(tbl[i].eb));
         end
      end

      // debounce: alternating values never settle
      tick(1'b1, 5'b00000, 1'b0, 1'b1);
      recs = 0;
      for (int i = 0; i < 24; i++) begin
         tick(1'b0, (i % 2 == 0) ? 5'b11100 : 5'b11000, 1'b1, 1'b1);
         if (obs_ov == 1) recs++;
      end
      chk("debounce_no_record", recs, 0);

      // extremes k=5 then k=0, each published once
      tick(1'b1, 5'b00000, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tick(1'b0, 5'b00000, 1'b1, 1'b1);
      watch(6, recs, lastk);
      chk("k5_records", recs, 1);
      chk("k5_value", lastk, 5);
      for (int i = 0; i < 3; i++) tick(1'b0, 5'b11111, 1'b1, 1'b1);
      watch(6, recs, lastk);
      chk("k0_records", recs, 1);
      chk("k0_value", lastk, 0);

      // reset while a record is pending, then republish the same value
      tick(1'b1, 5'b00000, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tick(1'b0, 5'b11100, 1'b1, 1'b0);
      waited = 0;
      while (obs_ov != 1 && waited < 8) begin
         tick(1'b0, 5'b00000, 1'b0, 1'b0);
         waited++;
      end
      chk("pre_reset_pending", obs_ov, 1);
      tick(1'b1, 5'b00000, 1'b0, 1'b0);
      tick(1'b0, 5'b00000, 1'b0, 1'b1);
      chk("post_reset_out_valid", obs_ov, 0);
      for (int i = 0; i < 3; i++) tick(1'b0, 5'b11100, 1'b1, 1'b1);
      watch(6, recs, lastk);
      chk("republish_records", recs, 1);
      chk("republish_value", lastk, 2);

      // randomized traffic against the model
      cur_k = 0;
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] full;
         full = 5'b11111;
         if ($urandom_range(5) == 0) cur_k = $urandom_range(N);
         t = full << cur_k;
         if ($urandom_range(7) == 0) t[$urandom_range(N - 1)] ^= 1'b1;
         tick(($urandom_range(199) == 0), t, ($urandom_range(3) != 0), ($urandom_range(2) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
